// File: rtl/inst_queue_pkg.sv
// Shared constants for the fetch unit and instruction queue: sizing,
// RV32I major opcodes, FSM state encoding and the queue entry layout.
package inst_queue_pkg;

  localparam int          IQ_DEPTH_BIT = 4;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_ARITH_I = 7'b0010011;
  localparam logic [6:0] OPC_ARITH_R = 7'b0110011;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT_JR = 2'd1,
    ST_DISCARD = 2'd2
  } iq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        guess;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Bus bundle between the fetch/queue unit, the icache, the decoder and the ROB.
// master = the instruction queue, slave = its environment.
interface inst_queue_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic [31:0] ic_inst;
  logic        iq_valid;
  logic [31:0] iq_pc;
  logic [31:0] iq_inst;
  logic        iq_guess;
  logic        iq_pop;
  logic        flush_in;
  logic [31:0] flush_pc;

  modport master (
    output ic_req, ic_addr, iq_valid, iq_pc, iq_inst, iq_guess,
    input  ic_ready, ic_inst, iq_pop, flush_in, flush_pc
  );

  modport slave (
    input  ic_req, ic_addr, iq_valid, iq_pc, iq_inst, iq_guess,
    output ic_ready, ic_inst, iq_pop, flush_in, flush_pc
  );
endinterface

// File: rtl/inst_queue_fetch_predecode.sv
// Static next-PC predictor for one fetched word: JAL always taken,
// backward branches predicted taken, everything else falls through.
module fetch_predecode
  import inst_queue_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_next_pc,
  output logic        o_guess,
  output logic        o_is_jalr
);

  logic [6:0]  w_opcode;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_b;

  assign w_opcode  = i_inst[6:0];
  assign w_imm_j   = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_imm_b   = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign o_is_jalr = (w_opcode == OPC_JALR);

  // Pick the predicted successor; all adds wrap at 32 bits.
  always_comb begin
    o_next_pc = i_pc + 32'd4;
    o_guess   = 1'b0;
    case (w_opcode)
      OPC_JAL: begin
        o_next_pc = i_pc + w_imm_j;
        o_guess   = 1'b1;
      end
      OPC_BRANCH: begin
        if (w_imm_b[31]) begin
          o_next_pc = i_pc + w_imm_b;
          o_guess   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_queue.sv
// Fetch unit plus circular instruction queue. Issues one icache request at
// a time, pre-decodes each returned word and buffers {pc, inst, guess}.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int          P_DEPTH_BIT = IQ_DEPTH_BIT,
  parameter logic [31:0] P_RESET_PC  = RESET_PC
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  inst_queue_if.master  bus
);

  localparam int                   DEPTH      = 1 << P_DEPTH_BIT;
  localparam logic [P_DEPTH_BIT:0] FULL_COUNT = (P_DEPTH_BIT + 1)'(DEPTH);

  iq_state_e              r_state, w_state_next;
  logic [P_DEPTH_BIT-1:0] r_head, r_tail;
  logic [P_DEPTH_BIT:0]   r_count;
  logic [31:0]            r_fetch_pc;
  logic                   r_pending;
  iq_entry_t              r_mem [DEPTH];

  logic        w_ic_req;
  logic [31:0] w_ic_addr;
  logic        w_busy;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_next_pc;
  logic        w_guess;
  logic        w_is_jalr;
  iq_entry_t   w_head;

  fetch_predecode u_predecode (
    .i_inst    (bus.ic_inst),
    .i_pc      (r_fetch_pc),
    .o_next_pc (w_next_pc),
    .o_guess   (w_guess),
    .o_is_jalr (w_is_jalr)
  );

  // A request is in flight either because we are asserting ic_req now or a
  // stale one is still owed a response after a flush.
  assign w_busy = w_ic_req | r_pending;
  assign w_push = rdy_in & ~bus.flush_in & (r_state == ST_FETCH) & w_ic_req & bus.ic_ready;
  assign w_pop  = rdy_in & ~bus.flush_in & bus.iq_pop & (r_count != '0);

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in)      r_state <= ST_FETCH;
    else if (rdy_in) r_state <= w_state_next;
  end

  // Next-state logic; flush overrides everything else.
  always_comb begin
    w_state_next = r_state;
    if (bus.flush_in) begin
      w_state_next = (w_busy && !bus.ic_ready) ? ST_DISCARD : ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH:   if (w_push && w_is_jalr) w_state_next = ST_WAIT_JR;
        ST_WAIT_JR: w_state_next = ST_WAIT_JR;
        ST_DISCARD: if (bus.ic_ready) w_state_next = ST_FETCH;
        default:    w_state_next = ST_FETCH;
      endcase
    end
  end

  // Request outputs. An outstanding request keeps ic_req high even if the
  // queue fills via earlier pushes, since its slot was reserved at issue.
  always_comb begin
    w_ic_req  = 1'b0;
    w_ic_addr = 32'h0;
    if (!rst_in && r_state == ST_FETCH && (r_pending || r_count < FULL_COUNT)) begin
      w_ic_req  = 1'b1;
      w_ic_addr = r_fetch_pc;
    end
  end

  // Pointers, occupancy, fetch PC and the outstanding-request flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= P_RESET_PC;
      r_pending  <= 1'b0;
    end else if (rdy_in) begin
      r_pending <= w_busy & ~bus.ic_ready;
      if (bus.flush_in) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_fetch_pc <= bus.flush_pc;
      end else begin
        if (w_push) begin
          r_tail     <= r_tail + 1'b1;
          r_fetch_pc <= w_next_pc;
        end
        if (w_pop) r_head <= r_head + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_tail] <= '{pc: r_fetch_pc, inst: bus.ic_inst, guess: w_guess};
  end

  assign w_head       = r_mem[r_head];
  assign bus.ic_req   = w_ic_req;
  assign bus.ic_addr  = w_ic_addr;
  assign bus.iq_valid = (r_count != '0);
  assign bus.iq_pc    = bus.iq_valid ? w_head.pc    : 32'h0;
  assign bus.iq_inst  = bus.iq_valid ? w_head.inst  : 32'h0;
  assign bus.iq_guess = bus.iq_valid ? w_head.guess : 1'b0;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a table of pre-decode vectors plus
// hand-written sequences for fill, flush, JALR stall and rdy freeze.
module tb_inst_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exp_next;
    logic        exp_guess;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs [7];

  inst_queue_if bus_if ();

  inst_queue u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus_if.ic_req && n < 32) begin
      tick();
      n++;
    end
    if (!bus_if.ic_req) begin
      n_total++;
      $display("FAIL %s: ic_req timeout got 0 expected 1", tag);
    end
  endtask

  task automatic respond(input logic [31:0] inst);
    bus_if.ic_ready = 1'b1;
    bus_if.ic_inst  = inst;
    tick();
    bus_if.ic_ready = 1'b0;
  endtask

  // Redirect with a response in the same cycle so no stale request survives.
  task automatic redirect(input logic [31:0] pc);
    bus_if.flush_in = 1'b1;
    bus_if.flush_pc = pc;
    bus_if.ic_ready = bus_if.ic_req;
    tick();
    bus_if.flush_in = 1'b0;
    bus_if.ic_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ic_req",   32'(bus_if.ic_req),   32'h0);
    chk("rst_ic_addr",  bus_if.ic_addr,       32'h0);
    chk("rst_iq_valid", 32'(bus_if.iq_valid), 32'h0);
    chk("rst_iq_pc",    bus_if.iq_pc,         32'h0);
    chk("rst_iq_inst",  bus_if.iq_inst,       32'h0);
    chk("rst_iq_guess", 32'(bus_if.iq_guess), 32'h0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pc: 32'h10, inst: 32'h0200006F, exp_next: 32'h30,       exp_guess: 1'b1}; // jal +0x20
    vecs[1] = '{pc: 32'h40, inst: 32'hFE000CE3, exp_next: 32'h38,       exp_guess: 1'b1}; // beq -8
    vecs[2] = '{pc: 32'h40, inst: 32'h00000463, exp_next: 32'h44,       exp_guess: 1'b0}; // beq +8
    vecs[3] = '{pc: 32'h50, inst: 32'hFFDFF06F, exp_next: 32'h4C,       exp_guess: 1'b1}; // jal -4
    vecs[4] = '{pc: 32'h00, inst: 32'hFFDFF06F, exp_next: 32'hFFFFFFFC, exp_guess: 1'b1}; // wraps
    vecs[5] = '{pc: 32'h60, inst: 32'h00002083, exp_next: 32'h64,       exp_guess: 1'b0}; // lw
    vecs[6] = '{pc: 32'h70, inst: 32'hFFFFFFFF, exp_next: 32'h74,       exp_guess: 1'b0}; // bad op

    bus_if.ic_ready = 1'b0;
    bus_if.ic_inst  = 32'h0;
    bus_if.iq_pop   = 1'b0;
    bus_if.flush_in = 1'b0;
    bus_if.flush_pc = 32'h0;
    #1;
    do_reset();

    // Straight-line nops, decoder pops every cycle.
    bus_if.iq_pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_req("t1_req");
      chk("t1_ic_addr", bus_if.ic_addr, 32'(4 * i));
      respond(32'h00000013);
      chk("t1_iq_valid", 32'(bus_if.iq_valid), 32'h1);
      chk("t1_iq_pc",    bus_if.iq_pc,         32'(4 * i));
      chk("t1_iq_guess", 32'(bus_if.iq_guess), 32'h0);
      $display("t1 pc=%h inst=%h guess=%0d", bus_if.iq_pc, bus_if.iq_inst, bus_if.iq_guess);
    end
    bus_if.iq_pop = 1'b0;

    // Pre-decode vectors.
    for (int v = 0; v < 7; v++) begin
      redirect(vecs[v].pc);
      chk("vec_fetch_addr", bus_if.ic_addr, vecs[v].pc);
      respond(vecs[v].inst);
      chk("vec_head_pc",   bus_if.iq_pc,          vecs[v].pc);
      chk("vec_head_inst", bus_if.iq_inst,        vecs[v].inst);
      chk("vec_guess",     32'(bus_if.iq_guess),  32'(vecs[v].exp_guess));
      chk("vec_next_addr", bus_if.ic_addr,        vecs[v].exp_next);
      $display("vec%0d pc=%h inst=%h next=%h guess=%0d", v, vecs[v].pc, vecs[v].inst,
               bus_if.ic_addr, bus_if.iq_guess);
    end

    // Fill the queue with no pops.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wait_req("t4_fill");
      respond(32'h00000013);
    end
    chk("t4_full_no_req", 32'(bus_if.ic_req), 32'h0);
    tick(); tick(); tick();
    chk("t4_full_hold", 32'(bus_if.ic_req), 32'h0);
    bus_if.iq_pop = 1'b1;
    tick();
    bus_if.iq_pop = 1'b0;
    chk("t4_pop_head",  bus_if.iq_pc,         32'h4);
    chk("t4_pop_req",   32'(bus_if.ic_req),   32'h1);
    chk("t4_pop_addr",  bus_if.ic_addr,       32'h40);
    respond(32'h00000013);
    chk("t4_refull",    32'(bus_if.ic_req),   32'h0);
    for (int k = 0; k < 16; k++) begin
      chk("t4_drain_pc", bus_if.iq_pc, 32'(4 * (k + 1)));
      bus_if.iq_pop = 1'b1;
      tick();
    end
    bus_if.iq_pop = 1'b0;
    chk("t4_drained", 32'(bus_if.iq_valid), 32'h0);
    $display("t4 fill/pop/drain done");

    // Flush while a request is outstanding.
    do_reset();
    respond(32'h00000013);
    tick();
    bus_if.flush_in = 1'b1;
    bus_if.flush_pc = 32'h100;
    tick();
    bus_if.flush_in = 1'b0;
    chk("t5_flush_empty",   32'(bus_if.iq_valid), 32'h0);
    chk("t5_discard_noreq", 32'(bus_if.ic_req),   32'h0);
    respond(32'h0000006F);
    chk("t5_stale_dropped", 32'(bus_if.iq_valid), 32'h0);
    chk("t5_req_after",     32'(bus_if.ic_req),   32'h1);
    chk("t5_addr_after",    bus_if.ic_addr,       32'h100);
    respond(32'h00000013);
    chk("t5_pushed_104",    bus_if.ic_addr,       32'h104);
    redirect(32'h100);
    chk("t5b_no_push",      32'(bus_if.iq_valid), 32'h0);
    chk("t5b_addr",         bus_if.ic_addr,       32'h100);
    $display("t5 flush addr=%h valid=%0d", bus_if.ic_addr, bus_if.iq_valid);

    // JALR stall, rdy freeze, then ROB redirect.
    redirect(32'h20);
    respond(32'h00008067);
    chk("t6_jalr_valid", 32'(bus_if.iq_valid), 32'h1);
    chk("t6_jalr_pc",    bus_if.iq_pc,         32'h20);
    chk("t6_jalr_inst",  bus_if.iq_inst,       32'h00008067);
    chk("t6_stall_req",  32'(bus_if.ic_req),   32'h0);
    chk("t6_stall_addr", bus_if.ic_addr,       32'h0);
    rdy = 1'b0;
    bus_if.iq_pop   = 1'b1;
    bus_if.flush_in = 1'b1;
    bus_if.flush_pc = 32'h80;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_frz_valid", 32'(bus_if.iq_valid), 32'h1);
      chk("t6_frz_pc",    bus_if.iq_pc,         32'h20);
      chk("t6_frz_req",   32'(bus_if.ic_req),   32'h0);
    end
    rdy = 1'b1;
    bus_if.iq_pop   = 1'b0;
    bus_if.flush_in = 1'b0;
    tick(); tick();
    chk("t6_still_wait", 32'(bus_if.ic_req), 32'h0);
    bus_if.flush_in = 1'b1;
    tick();
    bus_if.flush_in = 1'b0;
    chk("t6_flush_empty", 32'(bus_if.iq_valid), 32'h0);
    chk("t6_req",         32'(bus_if.ic_req),   32'h1);
    chk("t6_addr",        bus_if.ic_addr,       32'h80);
    rdy = 1'b0;
    bus_if.ic_ready = 1'b1;
    bus_if.ic_inst  = 32'h00000013;
    tick(); tick(); tick();
    chk("t6_frz_nopush", 32'(bus_if.iq_valid), 32'h0);
    chk("t6_frz_addr",   bus_if.ic_addr,       32'h80);
    bus_if.ic_ready = 1'b0;
    rdy = 1'b1;
    $display("t6 jalr redirect addr=%h", bus_if.ic_addr);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
